apb_slave_regfile: RTL and testbench



---
 rtl/apb_slave_pkg.sv | 37 +++
 rtl/apb_slave_stats.sv | 35 +++
 rtl/apb_slave_regfile.sv | 147 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types, counter offsets and address decoding
// for the APB register-file slave.
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Counter slots sit directly above the R/W registers
    localparam int WR_CNT_OFS  = 0;
    localparam int RD_CNT_OFS  = 1;
    localparam int ERR_CNT_OFS = 2;

    typedef struct packed {
        logic        valid;
        logic [29:0] idx;
    } dec_t;

    // Word index relative to base; valid only when aligned,
    // at or above base, and inside the register+counter window
    function automatic dec_t addr_decode(
        input logic [31:0] paddr,
        input logic [31:0] base,
        input int          nregs
    );
        logic [31:0] off;
        dec_t        d;
        off     = paddr - base;
        d.idx   = off[31:2];
        d.valid = (off[1:0] == 2'b00)
               && (paddr >= base)
               && ({2'b00, off[31:2]} < 32'(nregs + 3));
        return d;
    endfunction

endpackage

// File: rtl/apb_slave_stats.sv
// Write, read and error statistics counters.
// 32-bit, wrapping, cleared by synchronous reset.
module apb_slave_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc_wr,
    input  logic        i_inc_rd,
    input  logic        i_inc_err,
    output logic [31:0] o_wr_cnt,
    output logic [31:0] o_rd_cnt,
    output logic [31:0] o_err_cnt
);

    logic [31:0] r_wr_cnt;
    logic [31:0] r_rd_cnt;
    logic [31:0] r_err_cnt;

    // Count one event per strobe; natural 32-bit wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (i_inc_wr)  r_wr_cnt  <= r_wr_cnt + 32'd1;
            if (i_inc_rd)  r_rd_cnt  <= r_rd_cnt + 32'd1;
            if (i_inc_err) r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    assign o_wr_cnt  = r_wr_cnt;
    assign o_rd_cnt  = r_rd_cnt;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS R/W registers, three
// read-only statistics counters and an error pulse.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int          SLAVE_IDX = 0,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             Pselx,
    input  logic                    Penable,
    input  logic                    Pwrite,
    input  logic [31:0]             Paddr,
    input  logic [31:0]             Pwdata,
    output logic [31:0]             Prdata,
    output logic [NUM_REGS*32-1:0]  regs_flat,
    output logic                    err_pulse
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t      r_state;
    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_prdata;
    logic        r_err;
    logic [31:0] r_regs [NUM_REGS];

    logic        w_sel;
    dec_t        w_dec;
    logic [31:0] w_idx;
    logic [IW-1:0] w_ridx;
    logic        w_is_rw;
    logic        w_match;
    logic        w_commit;
    logic        w_inc_wr;
    logic        w_inc_rd;
    logic        w_inc_err;
    logic        w_reg_we;
    logic [31:0] w_rdval;
    logic [31:0] w_wr_cnt;
    logic [31:0] w_rd_cnt;
    logic [31:0] w_err_cnt;

    assign w_sel   = Pselx[SLAVE_IDX];
    assign w_dec   = addr_decode(Paddr, BASE_ADDR, NUM_REGS);
    assign w_idx   = {2'b00, w_dec.idx};
    assign w_ridx  = w_dec.idx[IW-1:0];
    assign w_is_rw = w_dec.valid && (w_idx < 32'(NUM_REGS));

    // Access phase must repeat the latched setup exactly
    assign w_match  = w_sel && Penable
                   && (Paddr == r_addr)
                   && (Pwrite == r_write);
    assign w_commit = (r_state == ACCESS) && w_match;

    assign w_inc_wr = w_commit && Pwrite && w_dec.valid;
    assign w_inc_rd = w_commit && !Pwrite && w_dec.valid;
    assign w_reg_we = w_commit && Pwrite && w_is_rw;

    // Enable without setup, broken access, or bad address
    assign w_inc_err = ((r_state == IDLE) && w_sel && Penable)
                    || ((r_state == ACCESS) && !w_match)
                    || (w_commit && !w_dec.valid);

    // Read-back mux over registers and counters
    always_comb begin
        w_rdval = '0;
        if (w_is_rw) begin
            w_rdval = r_regs[w_ridx];
        end else if (w_dec.valid) begin
            if (w_idx == 32'(NUM_REGS + WR_CNT_OFS))
                w_rdval = w_wr_cnt;
            else if (w_idx == 32'(NUM_REGS + RD_CNT_OFS))
                w_rdval = w_rd_cnt;
            else if (w_idx == 32'(NUM_REGS + ERR_CNT_OFS))
                w_rdval = w_err_cnt;
        end
    end

    // Setup/access sequencing; read data is loaded at setup
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_prdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_prdata <= '0;
                    if (w_sel && !Penable) begin
                        r_state  <= ACCESS;
                        r_addr   <= Paddr;
                        r_write  <= Pwrite;
                        r_prdata <= Pwrite ? 32'h0 : w_rdval;
                    end
                end
                ACCESS: begin
                    r_state  <= IDLE;
                    r_prdata <= '0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_prdata <= '0;
                end
            endcase
        end
    end

    // Register array; writes land on the access edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_reg_we) begin
            r_regs[w_ridx] <= Pwdata;
        end
    end

    // Error strobe is visible for the cycle after the edge
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_inc_err;
    end

    apb_slave_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .i_inc_wr  (w_inc_wr),
        .i_inc_rd  (w_inc_rd),
        .i_inc_err (w_inc_err),
        .o_wr_cnt  (w_wr_cnt),
        .o_rd_cnt  (w_rd_cnt),
        .o_err_cnt (w_err_cnt)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[32*g +: 32] = r_regs[g];
    end

    assign Prdata    = r_prdata;
    assign err_pulse = r_err;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: slave bit 3,
// 16 registers at base 0x100.
module tb_apb_slave_regfile;

    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic              clk;
    logic              rst;
    logic [31:0]       Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [31:0]       Paddr;
    logic [31:0]       Pwdata;
    logic [31:0]       Prdata;
    logic [NR*32-1:0]  regs_flat;
    logic              err_pulse;

    int checks;
    int failures;

    logic [31:0] psel_v;
    logic [31:0] exp_r [NR];
    logic [31:0] rdata;
    logic        obs_err;
    logic        obs_err_setup;
    logic [31:0] obs_pr_idle;

    apb_slave_regfile #(
        .SLAVE_IDX (3),
        .NUM_REGS  (NR),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .regs_flat (regs_flat),
        .err_pulse (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        logic [NR*32-1:0] e;
        for (int i = 0; i < NR; i++) e[32*i +: 32] = exp_r[i];
        checks++;
        assert (regs_flat === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, regs_flat, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        Pselx   = '0;
        Penable = 1'b0;
        repeat (n) tick();
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        Pselx   = psel_v;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = a;
        Pwdata  = d;
        tick();
        obs_err_setup = err_pulse;
        Penable = 1'b1;
        tick();
        obs_err = err_pulse;
        Penable = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
        Pselx   = psel_v;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = a;
        tick();
        obs_err_setup = err_pulse;
        d = Prdata;
        Penable = 1'b1;
        tick();
        obs_err     = err_pulse;
        obs_pr_idle = Prdata;
        Penable = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        psel_v   = 32'h8;
        for (int i = 0; i < NR; i++) exp_r[i] = '0;
        rst     = 1'b1;
        Pselx   = '0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = '0;
        Pwdata  = '0;
        repeat (2) tick();
        chk("rst_prdata", Prdata, 32'h0);
        chk("rst_err", {31'b0, err_pulse}, 32'h0);
        chk_regs("rst_regs");
        rst = 1'b0;
        idle(1);

        // write then back-to-back read of reg 2
        apb_wr(BASE + 32'h8, 32'hA5A5_0001);
        exp_r[2] = 32'hA5A5_0001;
        apb_rd(BASE + 32'h8, rdata);
        chk("rd_reg2", rdata, 32'hA5A5_0001);
        chk("reg2_flat", regs_flat[95:64], 32'hA5A5_0001);
        chk("prdata_idle", obs_pr_idle, 32'h0);

        // two more writes, one more read, then counters
        apb_wr(BASE + 32'h0, 32'h1111_2222);
        exp_r[0] = 32'h1111_2222;
        apb_wr(BASE + 32'h3C, 32'hDEAD_BEEF);
        exp_r[15] = 32'hDEAD_BEEF;
        apb_rd(BASE + 32'h0, rdata);
        chk("rd_reg0", rdata, 32'h1111_2222);
        apb_rd(BASE + 32'h40, rdata);
        chk("wr_cnt_3", rdata, 32'd3);
        apb_rd(BASE + 32'h44, rdata);
        chk("rd_cnt_3", rdata, 32'd3);
        chk_regs("regs_after_wr");

        // misaligned and out-of-window writes
        apb_wr(BASE + 32'h6, 32'h0000_1234);
        chk("err_misalign", {31'b0, obs_err}, 32'h1);
        apb_wr(BASE + 32'h4C, 32'h0000_5678);
        chk("err_range", {31'b0, obs_err}, 32'h1);
        chk_regs("regs_no_bad_wr");
        apb_rd(BASE + 32'h48, rdata);
        chk("err_cnt_2", rdata, 32'd2);
        chk("err_one_cycle", {31'b0, obs_err_setup}, 32'h0);
        apb_rd(BASE + 32'h6, rdata);
        chk("rd_misalign_0", rdata, 32'h0);
        chk("err_rd_misalign", {31'b0, obs_err}, 32'h1);
        apb_rd(BASE + 32'h4C, rdata);
        chk("rd_range_0", rdata, 32'h0);

        // write to read-only counter is counted, not stored
        apb_wr(BASE + 32'h40, 32'h0000_FFFF);
        chk("ro_wr_no_err", {31'b0, obs_err}, 32'h0);
        apb_rd(BASE + 32'h40, rdata);
        chk("wr_cnt_4", rdata, 32'd4);

        // enable without setup
        idle(1);
        Pselx   = psel_v;
        Penable = 1'b1;
        Pwrite  = 1'b1;
        Paddr   = BASE + 32'h4;
        Pwdata  = 32'd77;
        tick();
        chk("err_no_setup", {31'b0, err_pulse}, 32'h1);
        idle(1);
        chk("err_cleared", {31'b0, err_pulse}, 32'h0);

        // address changes between setup and access
        Pselx   = psel_v;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = BASE + 32'h4;
        Pwdata  = 32'h55;
        tick();
        Paddr   = BASE + 32'h8;
        Penable = 1'b1;
        tick();
        chk("err_addr_chg", {31'b0, err_pulse}, 32'h1);
        Penable = 1'b0;
        chk_regs("regs_no_abort_wr");
        apb_rd(BASE + 32'h48, rdata);
        chk("err_cnt_6", rdata, 32'd6);
        apb_rd(BASE + 32'h44, rdata);
        chk("rd_cnt_7", rdata, 32'd7);
        apb_rd(BASE + 32'h40, rdata);
        chk("wr_cnt_still_4", rdata, 32'd4);

        // other slave selected: ignored
        psel_v = 32'h1;
        apb_wr(BASE + 32'h0, 32'h0000_0BAD);
        chk("other_sel_no_err", {31'b0, obs_err}, 32'h0);
        chk_regs("other_sel_regs");
        // multi-hot including bit 3: serviced
        psel_v = 32'h9;
        apb_wr(BASE + 32'h4, 32'h0000_0009);
        exp_r[1] = 32'h0000_0009;
        chk_regs("multihot_regs");
        psel_v = 32'h8;
        apb_rd(BASE + 32'h40, rdata);
        chk("wr_cnt_5", rdata, 32'd5);
        apb_rd(BASE + 32'h48, rdata);
        chk("err_cnt_still_6", rdata, 32'd6);

        // reset lands on the access edge of a write
        Pselx   = psel_v;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = BASE;
        Pwdata  = 32'hFFFF_FFFF;
        tick();
        Penable = 1'b1;
        rst     = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) exp_r[i] = '0;
        chk_regs("rst_mid_regs");
        chk("rst_mid_prdata", Prdata, 32'h0);
        chk("rst_mid_err", {31'b0, err_pulse}, 32'h0);
        rst = 1'b0;
        idle(1);
        apb_rd(BASE + 32'h40, rdata);
        chk("post_rst_wr_cnt", rdata, 32'd0);
        apb_rd(BASE + 32'h44, rdata);
        chk("post_rst_rd_cnt", rdata, 32'd1);
        apb_rd(BASE + 32'h48, rdata);
        chk("post_rst_err_cnt", rdata, 32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
